glip_cypressfx3_write_scheduler: RTL
====================================

// Module: glip_cypressfx3_write_scheduler
// PURPOSE
//  Sequences the FPGA->host direction of the FX3 slave-FIFO port. Drains words from
//  the FX3-side CDC FIFO into the EP-IN socket and obtains the shared bus (fx3_dq/fx3_a)
//  through a req/gnt handshake with the read path. Flushes short packets with PKTEND
//  after an idle timeout. Sits between out_fifo_cdc and the FX3 pad logic, in the fx3_pclk domain.
// PARAMETERS
//  FIFO_ADDR           2'b00  fx3_a value selecting the EP-IN socket
//  PKT_WORDS           512    16-bit words per full USB packet; FX3 auto-commits at this count
//  FORCE_SEND_TIMEOUT  10000  idle cycles with a partial packet before PKTEND is issued
//  ADDR_SETUP          2      cycles fx3_a is held before the first write (address-to-flag latency)
// PORTS
//  clk             in   1   FX3 interface clock (fx3_pclk)
//  rst             in   1   asynchronous, active-high reset
//  src_valid       in   1   CDC FIFO not empty
//  src_ready       out  1   word popped from CDC FIFO this cycle
//  src_data        in   16  CDC FIFO read data
//  fx3_full        in   1   EP-IN full (active-high, already inverted from flaga)
//  fx3_almost_full in   1   EP-IN watermark reached (active-high, from flagb)
//  bus_req         out  1   request for fx3_dq/fx3_a ownership
//  bus_gnt         in   1   ownership granted; may drop at any cycle
//  fx3_wr          out  1   registered write strobe (drives ~fx3_slwr_n)
//  fx3_pktend      out  1   registered packet-end strobe (drives ~fx3_pktend_n)
//  fx3_addr        out  2   registered fx3_a
//  fx3_dq_out      out  16  registered write data
//  fx3_dq_oe       out  1   dq output enable; equals fx3_wr
// BEHAVIOUR
//  Reset: state=IDLE; bus_req, src_ready, fx3_wr, fx3_pktend, fx3_dq_oe=0; fx3_addr=0; fx3_dq_out=0;
//    pkt_cnt=0, idle_cnt=0, flush=0. Reset mid-burst aborts on the same edge; no PKTEND is issued.
//  pkt_cnt: words in current packet, $clog2(PKT_WORDS) bits. Wraps to 0 when PKT_WORDS-th word written.
//  idle_cnt: $clog2(FORCE_SEND_TIMEOUT+1) bits. Counts in IDLE only while pkt_cnt!=0 && !src_valid.
//    Cleared otherwise. Saturates; never wraps.
//  IDLE: bus_req=0.
//    src_valid && !fx3_full -> REQ, flush=0.
//    Else idle_cnt==FORCE_SEND_TIMEOUT-1 -> REQ, flush=1. Data has priority over flush on the same cycle.
//  REQ: bus_req=1. On bus_gnt: fx3_addr<=FIFO_ADDR, setup count=0 -> ADDR.
//  ADDR: bus_req=1; fx3_addr held ADDR_SETUP cycles.
//    bus_gnt low -> DONE. Else -> PKTEND if flush, else WRITE.
//  WRITE: src_ready = src_valid && bus_gnt && !fx3_almost_full && !fx3_full (combinational).
//    On accept: next edge fx3_wr=1, fx3_dq_out=src_data, pkt_cnt++ (1-cycle latency pop->strobe).
//    Exit to DONE the first cycle src_ready would be 0 for any reason.
//    A word accepted in that cycle is never lost.
//  PKTEND: one cycle. Next edge fx3_pktend=1, fx3_wr=0; pkt_cnt<=0, idle_cnt<=0, flush<=0 -> DONE.
//    Not entered if pkt_cnt==0 (no ZLP).
//  DONE: bus_req=0, strobes 0, fx3_dq_oe=0 -> IDLE (one turnaround cycle before any re-request).
//  fx3_addr holds its value outside ADDR/WRITE/PKTEND. fx3_wr and fx3_pktend are never high together.
//  fx3_full rising inside WRITE: no write issued that cycle; treated as watermark.
// TESTING
//  Reset, gnt tied 1, push 3 words 0x0001..0x0003
//    -> REQ 1 cyc, ADDR 2 cyc, then fx3_wr high 3 cycles with dq 1,2,3; pkt_cnt=3.
//  Then src idle -> exactly 10000 idle cycles later fx3_pktend pulses 1 cycle; pkt_cnt=0; no fx3_wr.
//  Stream 512 words
//    -> pkt_cnt wraps to 0 after word 512; no PKTEND afterwards even after 20000 idle cycles.
//  Assert fx3_almost_full after 100th accepted word
//    -> src_ready low that cycle; 100 writes total; DONE then IDLE.
//    Resume on deassert with word 101 intact.
//  Drop bus_gnt mid-burst
//    -> src_ready low same cycle; fx3_wr low next edge; bus_req low in DONE; re-request after 1 cycle.
//  Assert rst mid-WRITE -> all outputs at reset values asynchronously; pkt_cnt=0; no PKTEND after release.

Source files
------------

// File: rtl/glip_cypressfx3_write_scheduler.sv
// FPGA->host scheduler for the FX3 slave-FIFO port: drains the CDC FIFO into EP-IN,
// arbitrates the shared bus with the read path and flushes short packets with PKTEND.
module glip_cypressfx3_write_scheduler #(
  parameter logic [1:0] FIFO_ADDR          = 2'b00,
  parameter int         PKT_WORDS          = 512,
  parameter int         FORCE_SEND_TIMEOUT = 10000,
  parameter int         ADDR_SETUP         = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        src_valid,
  output logic        src_ready,
  input  logic [15:0] src_data,
  input  logic        fx3_full,
  input  logic        fx3_almost_full,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        fx3_wr,
  output logic        fx3_pktend,
  output logic [1:0]  fx3_addr,
  output logic [15:0] fx3_dq_out,
  output logic        fx3_dq_oe
);

  localparam int PW = $clog2(PKT_WORDS);
  localparam int IW = $clog2(FORCE_SEND_TIMEOUT + 1);
  localparam int SW = (ADDR_SETUP > 1) ? $clog2(ADDR_SETUP) : 1;

  localparam logic [PW-1:0] PKT_LAST   = PW'(PKT_WORDS - 1);
  localparam logic [IW-1:0] IDLE_TRIG  = IW'(FORCE_SEND_TIMEOUT - 1);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(FORCE_SEND_TIMEOUT);
  localparam logic [SW-1:0] SETUP_LAST = SW'(ADDR_SETUP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_ADDR, S_WRITE, S_PKTEND, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic [SW-1:0] setup_cnt_q, setup_cnt_d;
  logic          flush_q, flush_d;
  logic          fx3_wr_q, fx3_wr_d;
  logic          fx3_pktend_q, fx3_pktend_d;
  logic [1:0]    fx3_addr_q, fx3_addr_d;
  logic [15:0]   fx3_dq_q, fx3_dq_d;

  always_comb begin
    state_d      = state_q;
    pkt_cnt_d    = pkt_cnt_q;
    idle_cnt_d   = '0;
    setup_cnt_d  = setup_cnt_q;
    flush_d      = flush_q;
    fx3_wr_d     = 1'b0;
    fx3_pktend_d = 1'b0;
    fx3_addr_d   = fx3_addr_q;
    fx3_dq_d     = fx3_dq_q;
    src_ready    = 1'b0;
    bus_req      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pkt_cnt_q != '0 && !src_valid)
          idle_cnt_d = (idle_cnt_q == IDLE_MAX) ? idle_cnt_q : idle_cnt_q + IW'(1);
        // Pending data wins over a timeout flush on the same cycle.
        if (src_valid && !fx3_full) begin
          state_d = S_REQ;
          flush_d = 1'b0;
        end else if (idle_cnt_q == IDLE_TRIG && pkt_cnt_q != '0) begin
          state_d = S_REQ;
          flush_d = 1'b1;
        end
      end
      S_REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          fx3_addr_d  = FIFO_ADDR;
          setup_cnt_d = '0;
          state_d     = S_ADDR;
        end
      end
      S_ADDR: begin
        bus_req = 1'b1;
        if (!bus_gnt) begin
          state_d = S_DONE;
        end else if (setup_cnt_q == SETUP_LAST) begin
          if (!flush_q)              state_d = S_WRITE;
          else if (pkt_cnt_q != '0)  state_d = S_PKTEND;
          else                       state_d = S_DONE;
        end else begin
          setup_cnt_d = setup_cnt_q + SW'(1);
        end
      end
      S_WRITE: begin
        bus_req   = 1'b1;
        src_ready = src_valid && bus_gnt && !fx3_almost_full && !fx3_full;
        if (src_ready) begin
          fx3_wr_d  = 1'b1;
          fx3_dq_d  = src_data;
          pkt_cnt_d = (pkt_cnt_q == PKT_LAST) ? '0 : pkt_cnt_q + PW'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_PKTEND: begin
        bus_req      = 1'b1;
        fx3_pktend_d = 1'b1;
        pkt_cnt_d    = '0;
        flush_d      = 1'b0;
        state_d      = S_DONE;
      end
      S_DONE: begin
        // Turnaround cycle: bus released before the read path may drive it.
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pkt_cnt_q    <= '0;
      idle_cnt_q   <= '0;
      setup_cnt_q  <= '0;
      flush_q      <= 1'b0;
      fx3_wr_q     <= 1'b0;
      fx3_pktend_q <= 1'b0;
      fx3_addr_q   <= '0;
      fx3_dq_q     <= '0;
    end else begin
      state_q      <= state_d;
      pkt_cnt_q    <= pkt_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      setup_cnt_q  <= setup_cnt_d;
      flush_q      <= flush_d;
      fx3_wr_q     <= fx3_wr_d;
      fx3_pktend_q <= fx3_pktend_d;
      fx3_addr_q   <= fx3_addr_d;
      fx3_dq_q     <= fx3_dq_d;
    end
  end

  assign fx3_wr     = fx3_wr_q;
  assign fx3_dq_oe  = fx3_wr_q;
  assign fx3_pktend = fx3_pktend_q;
  assign fx3_addr   = fx3_addr_q;
  assign fx3_dq_out = fx3_dq_q;

endmodule
